// File: rtl/w_writeback_stage_pkg.sv
// Shared writeback-select and load-type codes for the D/E/M decoders and the W stage.
package w_writeback_stage_pkg;
  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_MEM  = 2'b01;
  localparam logic [1:0] WD_LINK = 2'b10;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  localparam logic [31:0] LINK_OFFSET = 32'd8;
endpackage

// File: rtl/w_writeback_stage_load_ext.sv
// Load data extractor: picks the addressed byte/halfword from the aligned word and extends it.
// Purely combinational; unknown load types fall back to the whole word.
module w_load_ext
  import w_writeback_stage_pkg::*;
(
  input  logic [31:0] i_dmrd,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_ld_type,
  output logic [31:0] o_data
);
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_off[1] ? i_dmrd[31:16] : i_dmrd[15:0];
    case (i_off)
      2'd0:    w_byte = i_dmrd[7:0];
      2'd1:    w_byte = i_dmrd[15:8];
      2'd2:    w_byte = i_dmrd[23:16];
      default: w_byte = i_dmrd[31:24];
    endcase
  end

  always_comb begin
    case (i_ld_type)
      LD_H:    o_data = {{16{w_half[15]}}, w_half};
      LD_HU:   o_data = {16'h0000, w_half};
      LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
      LD_BU:   o_data = {24'h000000, w_byte};
      default: o_data = i_dmrd;
    endcase
  end
endmodule

// File: rtl/w_writeback_stage.sv
// M/W pipeline register with writeback-data selection; drives the GRF write port.
// Optional retire/bubble counters appear when W_RETIRE_CNT_EN is defined.
module w_writeback_stage
  import w_writeback_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        M_Valid,
  input  logic [31:0] M_PC,
  input  logic        M_RegWrite,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_WDSel,
  input  logic [31:0] M_ALUOut,
  input  logic [31:0] M_DMRD,
  input  logic [2:0]  M_LdType,
  input  logic        W_Clr,
  output logic [31:0] W_PC,
  output logic        W_RFWr,
  output logic [4:0]  W_A3,
  output logic [31:0] W_WD,
  output logic        W_Valid
`ifdef W_RETIRE_CNT_EN
  ,
  output logic [31:0] Retire_Cnt,
  output logic [31:0] Bubble_Cnt
`endif
);
  logic [31:0] w_ext;
  logic [31:0] w_wd_next;
  logic        w_rfwr_next;
  logic        w_bubble;

  w_load_ext u_load_ext (
    .i_dmrd    (M_DMRD),
    .i_off     (M_ALUOut[1:0]),
    .i_ld_type (M_LdType),
    .o_data    (w_ext)
  );

  assign w_bubble = W_Clr | ~M_Valid;

  // Reserved select writes nothing, so its enable is dropped alongside the data.
  always_comb begin
    w_rfwr_next = M_RegWrite & (M_A3 != 5'd0);
    case (M_WDSel)
      WD_ALU:  w_wd_next = M_ALUOut;
      WD_MEM:  w_wd_next = w_ext;
      WD_LINK: w_wd_next = M_PC + LINK_OFFSET;
      default: begin
        w_wd_next   = 32'd0;
        w_rfwr_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      W_PC    <= RESET_PC;
      W_RFWr  <= 1'b0;
      W_A3    <= 5'd0;
      W_WD    <= 32'd0;
      W_Valid <= 1'b0;
    end else begin
      W_PC <= M_PC;
      if (w_bubble) begin
        W_RFWr  <= 1'b0;
        W_A3    <= 5'd0;
        W_WD    <= 32'd0;
        W_Valid <= 1'b0;
      end else begin
        W_RFWr  <= w_rfwr_next;
        W_A3    <= M_A3;
        W_WD    <= w_wd_next;
        W_Valid <= 1'b1;
      end
    end
  end

`ifdef W_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_retire_cnt <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else if (w_bubble) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign Retire_Cnt = r_retire_cnt;
  assign Bubble_Cnt = r_bubble_cnt;
`endif
endmodule

// File: doc/w_writeback_stage.md
Name: w_writeback_stage

Overview:
- M/W pipeline register plus writeback-data formation for the 5-stage MIPS core.
- Captures the retiring instruction from the M stage each cycle and selects ALU result, extended load data, or link address (PC+8, for jal/bgezal).
- Drives the GRF write port (WPC, RFWr, A3, WD) and exposes the same fields to the hazard unit for W→D/E forwarding.

Parameters:
- RESET_PC, 32'h0000_3000, value loaded into W_PC on reset.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst  input  1  asynchronous, active-high reset.
- M_Valid  input  1  M stage holds a real instruction; 0 means bubble.
- M_PC  input  32  PC of the M-stage instruction.
- M_RegWrite  input  1  instruction writes a GPR; for bgezal it is 1 whether or not the branch is taken.
- M_A3  input  5  destination register.
- M_WDSel  input  2  00 ALU, 01 memory, 10 link (PC+8), 11 reserved.
- M_ALUOut  input  32  ALU result; low 2 bits are the load byte offset.
- M_DMRD  input  32  raw aligned data-memory word.
- M_LdType  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; others are treated as LW.
- W_Clr  input  1  synchronous flush: next W content is a bubble.
- W_PC  output  32  PC of the retiring instruction (GRF WPC).
- W_RFWr  output  1  GRF write enable.
- W_A3  output  5  GRF write address.
- W_WD  output  32  GRF write data.
- W_Valid  output  1  W holds a real instruction.

Behaviour:
- Latency 1: the M-stage values present at posedge N appear on the W_* outputs after posedge N. There is no stall input; W always advances.
- Reset (asynchronous, immediate, overrides everything): W_PC=RESET_PC, W_RFWr=0, W_A3=0, W_WD=0, W_Valid=0.
- Capture rule (posedge, Rst low):
  - If W_Clr=1 or M_Valid=0: load a bubble. W_Valid=0, W_RFWr=0, W_A3=0, W_WD=0, W_PC=M_PC.
  - Otherwise: W_Valid=1, W_PC=M_PC, W_A3=M_A3, W_RFWr=M_RegWrite & (M_A3!=0), W_WD=sel(M_WDSel).
- W_WD is registered; no combinational path runs from M inputs to W outputs.
- sel:
  - 00 → M_ALUOut.
  - 01 → ext(M_DMRD).
  - 10 → M_PC+32'd8, with wrap-around modulo 2^32.
  - 11 → 0 with W_RFWr forced to 0.
- ext, with off = M_ALUOut[1:0]:
  - LW: the whole word; off is ignored.
  - LH/LHU: halfword M_DMRD[16*off[1] +: 16], sign- or zero-extended. off[0] is ignored; misalignment is trapped upstream.
  - LB/LBU: byte M_DMRD[8*off +: 8], sign- or zero-extended.
- A3=0 never produces W_RFWr=1, even when M_RegWrite=1. This matches the GRF's $0 guard.
- Simultaneous W_Clr and valid M input: flush wins.
- Reset released mid-stream: the first posedge after release captures normally.

Optional Feature:
- Macro: W_RETIRE_CNT_EN.
- When defined, two output ports are added:
  - Retire_Cnt [31:0]: increments on each posedge that loads W_Valid=1; wraps from 32'hFFFF_FFFF to 0; async-reset to 0.
  - Bubble_Cnt [31:0]: increments on each posedge that loads a bubble; same wrap and reset rules.
- When undefined, neither port nor any counter logic exists, and the module is identical in all other respects.

Decomposition:
- Shared package/header holds the WDSel codes (WD_ALU=2'b00, WD_MEM=2'b01, WD_LINK=2'b10) and the LdType codes (LD_W..LD_BU = 0..4).
- The D/E/M stage decoders include the same header.
- One sub-module, w_load_ext: purely combinational (M_DMRD, off, LdType) → 32-bit extended data, instantiated once before the W register.

Test Plan:
- Reset with Rst pulsed mid-cycle → outputs clear immediately without waiting for Clk: W_PC=32'h3000, W_RFWr=0, W_WD=0.
- ALU write: valid, A3=5'd8, WDSel=00, ALUOut=32'h1234_5678 → next cycle W_RFWr=1, W_A3=8, W_WD=32'h1234_5678.
- Load extension with M_DMRD=32'h80FF_7F01:
  - LB off=3 → 32'hFFFF_FF80.
  - LBU off=3 → 32'h0000_0080.
  - LH off=2 → 32'hFFFF_80FF.
  - LHU off=0 → 32'h0000_7F01.
  - LW off=2 → 32'h80FF_7F01.
- bgezal link: WDSel=10, A3=31, PC=32'h0000_3010 → W_WD=32'h0000_3018, W_RFWr=1. A second case with PC=32'hFFFF_FFFC → W_WD=32'h0000_0004.
- $0 and bubble suppression:
  - A3=0 with RegWrite=1 → W_RFWr=0, W_Valid=1.
  - M_Valid=0 → W_Valid=0, W_RFWr=0.
  - W_Clr=1 with valid M input → bubble.
- With W_RETIRE_CNT_EN defined: 3 valid instructions + 2 bubbles → Retire_Cnt=3, Bubble_Cnt=2. Preload Retire_Cnt=32'hFFFF_FFFF, retire one more → Retire_Cnt=0.
